// File: rtl/debounce_pulse.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debounce_pulse
// Purpose  : Cleans up a raw, bouncy, asynchronous board input. Produces a
//            debounced level and one-cycle press/release event pulses.
//            Optional auto-repeat of press_pulse while the input is held,
//            compiled in when the DEBOUNCE_REPEAT_EN macro is defined.
// Ports    : CLK50MHZ      - system clock (50 MHz)
//            rst           - asynchronous, active-high reset
//            btn_in        - raw pad input, asynchronous, may bounce
//            en            - pulse enable (sampled on the commit edge only)
//            level         - debounced, registered level of btn_in
//            press_pulse   - one cycle high per debounced rising edge
//                            (and per repeat when DEBOUNCE_REPEAT_EN)
//            release_pulse - one cycle high per debounced falling edge
// Revision : 1.0 - initial release
// ============================================================================
module debounce_pulse #(
  parameter int STABLE_CYCLES = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic CLK50MHZ,
  input  logic rst,
  input  logic btn_in,
  input  logic en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  // Largest terminal value the counter is ever asked to reach; used as a
  // saturation ceiling so the counter can never wrap.
  localparam int c_max_sr  = (STABLE_CYCLES > REPEAT_DELAY) ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int c_max_all = (c_max_sr > REPEAT_PERIOD) ? c_max_sr : REPEAT_PERIOD;

  localparam logic [CNT_W-1:0] c_cnt_max     = CNT_W'(c_max_all);
  localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_zero    = '0;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] c_delay_last  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_period_last = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

`ifdef DEBOUNCE_REPEAT_EN
  // 0: waiting out REPEAT_DELAY after entering HIGH; 1: REPEAT_PERIOD cadence
  logic             r_rep_phase;
`endif

  // Saturating increment; the terminal compares normally fire well below
  // the ceiling, this only guarantees the counter can never wrap.
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : (r_cnt + c_cnt_one);

  always_ff @(posedge CLK50MHZ or posedge rst) begin
    if (rst) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_state       <= ST_LOW;
      r_cnt         <= c_cnt_zero;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_rep_phase   <= 1'b0;
`endif
    end else begin
      // Two-stage synchronizer; only r_s2 is safe to use downstream.
      r_s1          <= btn_in;
      r_s2          <= r_s1;
      // Pulses default low so every pulse lasts exactly one cycle.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;

      case (r_state)
        ST_LOW: begin
          if (r_s2) begin
            r_state <= ST_WAIT_HIGH;
            r_cnt   <= c_cnt_one;
          end
        end

        ST_WAIT_HIGH: begin
          if (!r_s2) begin
            r_state <= ST_LOW;
            r_cnt   <= c_cnt_zero;
          end else if (r_cnt == c_stable_last) begin
            r_state     <= ST_HIGH;
            level       <= 1'b1;
            press_pulse <= en;
            r_cnt       <= c_cnt_zero;
`ifdef DEBOUNCE_REPEAT_EN
            r_rep_phase <= 1'b0;
`endif
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        ST_HIGH: begin
          if (!r_s2) begin
            r_state <= ST_WAIT_LOW;
            r_cnt   <= c_cnt_one;
          end
`ifdef DEBOUNCE_REPEAT_EN
          else if (r_cnt == (r_rep_phase ? c_period_last : c_delay_last)) begin
            press_pulse <= en;
            r_cnt       <= c_cnt_zero;
            r_rep_phase <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
`endif
        end

        ST_WAIT_LOW: begin
          if (r_s2) begin
            // Glitch back high: stay pressed, restart repeat timing.
            r_state <= ST_HIGH;
            r_cnt   <= c_cnt_zero;
`ifdef DEBOUNCE_REPEAT_EN
            r_rep_phase <= 1'b0;
`endif
          end else if (r_cnt == c_stable_last) begin
            r_state       <= ST_LOW;
            level         <= 1'b0;
            release_pulse <= en;
            r_cnt         <= c_cnt_zero;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state <= ST_LOW;
          r_cnt   <= c_cnt_zero;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/debounce_pulse.md
Name: debounce_pulse

Overview:
- Upstream conditioning stage for the generic event counter: takes a raw, asynchronous, bouncy board input (push-button, switch, rotary contact) and produces a clean debounced level plus single-cycle event pulses.
- `press_pulse` drives the counter's counted-signal input (`sig`) directly: one pulse per genuine press, never more than one per bounce burst.
- Optionally generates auto-repeat pulses while the input is held.

Parameters:
- STABLE_CYCLES, 500000, consecutive synchronized samples that must agree before the level changes (10 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY, 25000000, cycles held high after the press before the first repeat pulse (0.5 s); used only with the optional feature.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (0.1 s); used only with the optional feature; must be >= 1.
- CNT_W, 25, width of the internal cycle counter; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLK50MHZ  input  1  system clock, 50 MHz.
- rst  input  1  reset; asynchronous, active-high.
- btn_in  input  1  raw pad signal, asynchronous to CLK50MHZ, may bounce.
- en  input  1  pulse enable; when low, `press_pulse` and `release_pulse` are forced low (level tracking continues).
- level  output  1  debounced, registered level of `btn_in`.
- press_pulse  output  1  one-cycle high on each debounced rising edge (and on each repeat when the feature is compiled in).
- release_pulse  output  1  one-cycle high on each debounced falling edge.

Behaviour:
- Reset (async assert, state held while `rst` is high):
  - sync FFs = 0, state = LOW, counter = 0.
  - `level` = 0, `press_pulse` = 0, `release_pulse` = 0.
  - After release, the first update occurs on the next CLK50MHZ rising edge.
- Synchronizer:
  - Two flip-flop chain `btn_in` -> `s1` -> `s2`; only `s2` is used downstream.
  - Input-to-`s2` latency is 2 edges.
- FSM states: LOW, WAIT_HIGH, HIGH, WAIT_LOW; `level` = 1 in HIGH and WAIT_LOW, otherwise 0.
  - LOW: if `s2` = 1, go to WAIT_HIGH with counter = 1; else stay.
  - WAIT_HIGH:
    - `s2` = 0: go back to LOW, counter = 0 (bounce rejected, no pulse).
    - `s2` = 1 and counter = STABLE_CYCLES-1: go to HIGH, `level` <= 1, `press_pulse` <= `en`, counter = 0.
    - Otherwise counter++.
  - HIGH: if `s2` = 0, go to WAIT_LOW with counter = 1; else stay (repeat timing only with the optional feature).
  - WAIT_LOW: mirror of WAIT_HIGH. Commit gives `level` <= 0 and `release_pulse` <= `en`; a glitch back to 1 returns to HIGH.
- Net effect: `level` changes on the edge at which `s2` has been sampled at the new value on STABLE_CYCLES consecutive edges. Total latency from a clean `btn_in` step is STABLE_CYCLES+2 edges.
- Pulses:
  - Registered, high for exactly one cycle.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
  - `en` is sampled on the commit edge only; dropping `en` later does not truncate an already-issued pulse.
- Counter:
  - Unsigned, CNT_W bits, compared with ==.
  - Never exceeds its terminal value and never wraps.
- Reset mid-WAIT: the pending transition is discarded and no pulse is issued after reset release.
- `btn_in` held high through reset release: a press is detected normally after STABLE_CYCLES+2 edges (the press is not lost).

Optional Feature:
- Macro: DEBOUNCE_REPEAT_EN.
- Defined:
  - In HIGH, the counter runs.
  - When it reaches REPEAT_DELAY-1, `press_pulse` <= `en` and the counter is cleared.
  - Thereafter a pulse is issued every REPEAT_PERIOD cycles while in HIGH.
  - Leaving HIGH (to WAIT_LOW) reloads the counter as above and cancels repeat timing.
  - Returning from WAIT_LOW to HIGH on a glitch restarts the REPEAT_DELAY phase.
- Undefined: HIGH ignores the counter, no repeat pulses; exactly one `press_pulse` per debounced press.
- Default: not defined.

Test Plan:
- Sim params for all scenarios: STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=5.
- Reset: `rst` pulsed asynchronously mid-cycle -> all outputs 0 immediately. A reset issued 2 cycles into a WAIT_HIGH -> no `press_pulse` afterwards.
- Clean press: `btn_in` 0->1 held, `en` = 1 -> `level` rises and `press_pulse` is high exactly 1 cycle, 6 edges after the step. Release held -> `release_pulse` 1 cycle, 6 edges after the step.
- Bounce rejection: `btn_in` toggles 1,0,1,0,1 with 2-cycle runs, then held 1 -> no pulse during the bounce; a single `press_pulse` 6 edges after the final rise.
- Enable gating: press committed while `en` = 0 -> `level` = 1, `press_pulse` stays 0. Release with `en` = 1 -> `release_pulse` = 1.
- Counter chain: `press_pulse` into the counter's `sig` with `cnt_en` = 1, MAX=4. Press 3 times cleanly (with 20 bounce toggles each) -> counter = 3 and the tick asserts after the 3rd press.
- Repeat (DEBOUNCE_REPEAT_EN defined): hold 40 cycles after commit -> `press_pulse` at commit, +10, +13, +16, ... The same test without the macro -> exactly 1 pulse.
